ling_cla_adder_pipe: RTL and testbench

- Parametrised, two-stage pipelined adder/subtractor built on Ling carry-lookahead groups of 4 bits, with a second lookahead level across the groups.
- Replaces fixed 4-bit lookahead generation with a WIDTH-generic datapath.
- Adds subtract mode, signed overflow detection and a valid/ready handshake with full backpressure.
- Sits in the arithmetic library as the default registered adder for datapaths.

---
 rtl/ling_cla_adder_pipe_if.sv | 27 ++
 rtl/ling_cla_adder_pipe.sv | 137 +++++++++++++
 tb/tb_ling_cla_adder_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ling_cla_adder_pipe_if.sv
// Valid/ready bundle for the pipelined Ling adder: operand beat in, result beat out.
// The design takes the slave view; the producer/consumer side takes the master view.
interface ling_cla_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/ling_cla_adder_pipe.sv
// Two-stage adder/subtractor: stage 1 builds 4-bit Ling groups, stage 2 runs the
// group-level lookahead, recovers real carries and registers the result.
module ling_cla_adder_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  ling_cla_adder_pipe_if.slave bus
);
  localparam int unsigned GROUPS = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("ling_cla_adder_pipe: WIDTH must be a multiple of 4 within 4..64");
  end

  logic s1_valid_q, s1_valid_d, s2_valid_q;
  logic s2_load, in_ready, accept;

  assign s2_load    = !s2_valid_q || bus.out_ready;
  assign in_ready   = !s1_valid_q || s2_load;
  assign accept     = bus.in_valid && in_ready;
  assign s1_valid_d = accept || (s1_valid_q && !s2_load);

  // Stage 1: operand prep and per-group Ling terms
  logic [WIDTH-1:0]            b_eff, g, p, x_d;
  logic                        c0_d;
  logic [GROUPS-1:0][3:1]      hg_d;
  logic [GROUPS-1:0][3:2]      hp_d;
  logic [GROUPS-1:0]           hh_d, gp_d;

  always_comb begin
    b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    c0_d  = bus.in_sub ? 1'b1 : bus.in_cin;
    g     = bus.in_a & b_eff;
    p     = bus.in_a | b_eff;
    x_d   = bus.in_a ^ b_eff;
    hg_d  = '0;
    hp_d  = '0;
    hh_d  = '0;
    gp_d  = '0;
    // Pseudo-carry into bit k of a group is hg[k] | hp[k] & group_cin
    for (int j = 0; j < int'(GROUPS); j++) begin
      hg_d[j][1] = g[4*j];
      hg_d[j][2] = g[4*j+1] | g[4*j];
      hg_d[j][3] = g[4*j+2] | g[4*j+1] | (p[4*j+1] & g[4*j]);
      hp_d[j][2] = p[4*j];
      hp_d[j][3] = p[4*j+1] & p[4*j];
      hh_d[j]    = g[4*j+3] | g[4*j+2] | (p[4*j+2] & g[4*j+1])
                 | (p[4*j+2] & p[4*j+1] & g[4*j]);
      gp_d[j]    = &p[4*j +: 4];
    end
  end

  logic [WIDTH-1:0]       x_q, p_q;
  logic                   c0_q, a_msb_q, b_msb_q;
  logic [GROUPS-1:0][3:1] hg_q;
  logic [GROUPS-1:0][3:2] hp_q;
  logic [GROUPS-1:0]      hh_q, gp_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      x_q     <= x_d;
      p_q     <= p;
      c0_q    <= c0_d;
      a_msb_q <= bus.in_a[WIDTH-1];
      b_msb_q <= b_eff[WIDTH-1];
      hg_q    <= hg_d;
      hp_q    <= hp_d;
      hh_q    <= hh_d;
      gp_q    <= gp_d;
    end
  end

  // Stage 2: group lookahead, carry recovery, sum
  logic [GROUPS-1:0] grp_gen;
  logic [GROUPS:0]   cg;
  logic [WIDTH-1:0]  carry, sum_d;
  logic              cg_acc, pp;

  always_comb begin
    grp_gen = '0;
    cg      = '0;
    carry   = '0;
    cg_acc  = 1'b0;
    pp      = 1'b1;
    for (int j = 0; j < int'(GROUPS); j++) begin
      grp_gen[j] = p_q[4*j+3] & hh_q[j];
    end
    cg[0] = c0_q;
    for (int j = 0; j < int'(GROUPS); j++) begin
      cg_acc = 1'b0;
      pp     = 1'b1;
      for (int k = j; k >= 0; k--) begin
        cg_acc = cg_acc | (pp & grp_gen[k]);
        pp     = pp & gp_q[k];
      end
      cg[j+1] = cg_acc | (pp & c0_q);
    end
    for (int j = 0; j < int'(GROUPS); j++) begin
      carry[4*j]   = cg[j];
      carry[4*j+1] = p_q[4*j]   & (hg_q[j][1] | cg[j]);
      carry[4*j+2] = p_q[4*j+1] & (hg_q[j][2] | (hp_q[j][2] & cg[j]));
      carry[4*j+3] = p_q[4*j+2] & (hg_q[j][3] | (hp_q[j][3] & cg[j]));
    end
    sum_d = x_q ^ carry;
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q  <= sum_d;
          cout_q <= cg[GROUPS];
          // Same-sign operands giving an opposite-sign result
          ovf_q  <= (a_msb_q ~^ b_msb_q) & (a_msb_q ^ sum_d[WIDTH-1]);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_ling_cla_adder_pipe.sv
// Bench for ling_cla_adder_pipe: directed 16-bit table and corner sequences plus
// randomised sweeps at widths 4/8/32/64, all checked through per-instance scoreboards.
module tb_ling_cla_adder_pipe;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ling_cla_adder_pipe_if #(.WIDTH(W)) bus ();
  ling_cla_adder_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t exp_q[$];
  int   n_out = 0;
  vec_t tbl[10];

  function automatic res_t model16(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
    logic [W-1:0] bp;
    logic         c0;
    logic [W:0]   full;
    res_t         r;
    bp     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  always @(negedge clk) begin : mon16
    res_t e;
    if (rst) begin
      exp_q.delete();
    end else if (bus.out_valid && bus.out_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got sum=%h cout=%b ovf=%b, expected no beat",
                 bus.out_sum, bus.out_cout, bus.out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_sum, bus.out_cout, bus.out_ovf} !== e) begin
          errors++;
          $display("FAIL result16: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   bus.out_sum, bus.out_cout, bus.out_ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  // Presents one beat, pushes its expectation on acceptance, returns 1 after the edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input res_t e);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready in 64 cycles, expected acceptance");
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Random sweeps at other widths, each with its own reset and scoreboard
  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int unsigned SW = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
    typedef struct packed {
      logic [SW-1:0] sum;
      logic          cout;
      logic          ovf;
    } sres_t;

    logic  srst;
    bit    done = 1'b0;
    sres_t sq[$];

    ling_cla_adder_pipe_if #(.WIDTH(SW)) sbus ();
    ling_cla_adder_pipe #(.WIDTH(SW)) sdut (.clk(clk), .rst(srst), .bus(sbus));

    function automatic sres_t smodel(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                     input logic cin, input logic sub);
      logic [SW-1:0] bp;
      logic          c0;
      logic [SW:0]   full;
      sres_t         r;
      bp     = sub ? ~b : b;
      c0     = sub ? 1'b1 : cin;
      full   = {1'b0, a} + {1'b0, bp} + {{SW{1'b0}}, c0};
      r.sum  = full[SW-1:0];
      r.cout = full[SW];
      r.ovf  = (a[SW-1] == bp[SW-1]) && (full[SW-1] != a[SW-1]);
      return r;
    endfunction

    always @(negedge clk) begin : smon
      sres_t e;
      if (!srst) begin
        if (sbus.out_valid && sbus.out_ready) begin
          checks++;
          if (sq.size() == 0) begin
            errors++;
            $display("FAIL sweep%0d_unexpected: got sum=%h, expected no beat", SW, sbus.out_sum);
          end else begin
            e = sq.pop_front();
            if ({sbus.out_sum, sbus.out_cout, sbus.out_ovf} !== e) begin
              errors++;
              $display("FAIL sweep%0d: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                       SW, sbus.out_sum, sbus.out_cout, sbus.out_ovf, e.sum, e.cout, e.ovf);
            end
          end
        end
        if (sbus.in_valid && sbus.in_ready)
          sq.push_back(smodel(sbus.in_a, sbus.in_b, sbus.in_cin, sbus.in_sub));
      end
    end

    initial begin : sdrv
      logic [63:0] ra, rb;
      bit          acc;
      srst           = 1'b1;
      sbus.in_valid  = 1'b0;
      sbus.in_a      = '0;
      sbus.in_b      = '0;
      sbus.in_cin    = 1'b0;
      sbus.in_sub    = 1'b0;
      sbus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      srst = 1'b0;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        acc = sbus.in_valid && sbus.in_ready;
        @(posedge clk);
        #1;
        sbus.out_ready = ($urandom_range(0, 3) != 0);
        if (!sbus.in_valid || acc) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          sbus.in_valid = ($urandom_range(0, 3) != 0);
          sbus.in_cin   = $urandom_range(0, 1) == 1;
          sbus.in_sub   = $urandom_range(0, 1) == 1;
          sbus.in_a     = ra[SW-1:0];
          sbus.in_b     = rb[SW-1:0];
          // Force full carry ripple through every group now and then
          if ($urandom_range(0, 7) == 0) begin
            sbus.in_a = sbus.in_sub ? '0 : '1;
            sbus.in_b = '0;
            sbus.in_cin = 1'b1;
          end
        end
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      sbus.in_valid  = 1'b0;
      sbus.out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
        if (sq.size() == 0) break;
        @(posedge clk);
        #1;
      end
      check($sformatf("sweep%0d_drain", SW), 64'(sq.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin : main
    res_t        e;
    logic [W-1:0] held;
    int          n_before;
    bit          seen;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[9] = '{16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum", 64'(bus.out_sum), 64'd0);
    check("rst_out_cout", 64'(bus.out_cout), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Table vectors, streamed back to back
    for (int i = 0; i < 10; i++) begin
      e = '{sum: tbl[i].sum, cout: tbl[i].cout, ovf: tbl[i].ovf};
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
    end
    drain("table_drain");

    // Latency: result appears on the second edge after acceptance
    send(16'h0102, 16'h0304, 1'b0, 1'b0, model16(16'h0102, 16'h0304, 1'b0, 1'b0));
    check("latency_1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_2", 64'(bus.out_valid), 64'd1);
    drain("latency_drain");

    // Backpressure: 5 beats, out_ready low for 4 cycles from first out_valid
    n_before      = n_out;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic [W-1:0] ra, rb;
          ra = W'($urandom);
          rb = W'($urandom);
          send(ra, rb, k[0], k[1], model16(ra, rb, k[0], k[1]));
        end
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("bp_out_valid_seen", 64'(seen), 64'd1);
        held = bus.out_sum;
        check("bp_accepted", 64'(exp_q.size()), 64'd2);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          #1;
          check("bp_sum_stable", 64'(bus.out_sum), 64'(held));
          check("bp_valid_held", 64'(bus.out_valid), 64'd1);
          check("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", 64'(n_out - n_before), 64'd5);

    // Reset with two beats in flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model16(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h4444, 1'b0, 1'b0, model16(16'h3333, 16'h4444, 1'b0, 1'b0));
    n_before = n_out;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_sum", 64'(bus.out_sum), 64'd0);
    check("mid_rst_out_cout", 64'(bus.out_cout), 64'd0);
    check("mid_rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    check("mid_rst_no_output", 64'(n_out - n_before), 64'd0);

    // Pipeline still works after the mid-stream reset
    send(16'hABCD, 16'h1234, 1'b0, 1'b1, model16(16'hABCD, 16'h1234, 1'b0, 1'b1));
    drain("post_rst_drain");

    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("sweeps_done", 64'(seen), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
